pe_operand_feeder: RTL
======================

// Module: pe_operand_feeder
// PURPOSE
//  Transmit-side driver for one systolic PE's operand/start interface. Holds two
//  local operand vectors A and B loaded by the host, then sequences a dot-product job:
//  - one start pulse;
//  - N (a,b) word pairs, respecting PE full flags;
//  - capture of the PE result on fout.
//  Sits between the host/control bus and the first PE of a row/column.
// PARAMETERS
//  DW    16  operand/result width (signed)
//  DEPTH 16  words per local vector buffer (A and B each)
//  CW    8   width of length/counter fields (matches PE max_cntr)
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      async active-low reset
//  ld_we       in   1      host buffer write strobe
//  ld_sel      in   1      0=A buffer, 1=B buffer
//  ld_addr     in   log2(DEPTH)  buffer word address
//  ld_data     in   DW     buffer write data
//  go          in   1      start job (1-cycle pulse)
//  len         in   CW     vector length N, sampled on accepted go
//  busy        out  1      job in progress
//  done        out  1      1-cycle pulse: result valid
//  cfg_err     out  1      1-cycle pulse: go rejected (len>DEPTH)
//  res         out  DW     captured pe_s_out (signed)
//  res_sat     out  1      captured pe_sat
//  pe_start    out  1      to PE start
//  pe_awe      out  1      to PE awe
//  pe_bwe      out  1      to PE bwe
//  pe_a        out  DW     to PE a_in
//  pe_b        out  DW     to PE b_in
//  pe_ais      out  1      to PE ais, held 0 (direct input path)
//  pe_bis      out  1      to PE bis, held 0
//  pe_max_cntr out  CW     to PE max_cntr = latched N
//  pe_aff      in   1      PE A input full
//  pe_bff      in   1      PE B input full
//  pe_fout     in   1      PE result valid
//  pe_sat      in   1      PE saturation flag
//  pe_s_out    in   DW     PE result
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, idx=0, pe_max_cntr=0. Reset mid-job aborts
//    immediately; the buffers need no reset (contents are don't-care).
//  - FSM states: IDLE -> START -> STREAM -> WAIT_RES -> IDLE.
//  - IDLE, go=1:
//    - len==0: done=1 next cycle with res=0, res_sat=0; no pe_start.
//    - len>DEPTH: cfg_err=1 next cycle; stay IDLE.
//    - otherwise: latch N; go to START; busy=1.
//  - START: pe_start=1 for exactly one cycle; idx=0; then STREAM.
//  - STREAM: issue pair idx when !pe_aff && !pe_bff. pe_awe and pe_bwe are always
//    asserted together, with pe_a=A[idx] and pe_b=B[idx] registered in that cycle,
//    and idx increments. Either full flag stalls both streams, with no reordering
//    and no drop. After pair N-1 is issued, go to WAIT_RES.
//  - Latency: go at cycle t -> pe_start at t+1 -> first pe_awe at t+2 if not full.
//  - Outputs: pe_a and pe_b are 0 whenever their write enable is 0.
//  - Results: pe_fout is captured in STREAM or WAIT_RES (res<=pe_s_out,
//    res_sat<=pe_sat). done pulses once when all N pairs are issued AND the result is
//    captured, then return to IDLE. A fout that arrives while still streaming is held
//    until the stream completes. fout in IDLE/START is ignored.
//  - Host interface: ld_we writes A/B in IDLE only; ignored while busy. go while busy
//    is ignored. ld_we and go in the same cycle: the write lands first, the job uses
//    the new word.
//  - Widths: idx and N are CW bits. len==DEPTH is legal (full buffer, no wrap).
// CONFIGURATION
//  FEEDER_PACE_EN defined: at least one idle cycle is forced between consecutive pairs
//  (awe/bwe toggle 1,0,1,0...) for PEs needing a bubble; stall rules are unchanged.
//  Undefined: back-to-back pairs every cycle when not full.
// STRUCTURE
//  - Shared package/header pe_pkg: DW/CW defaults, FSM state localparams
//    (ST_IDLE, ST_START, ST_STREAM, ST_WAIT).
//  - One sub-module, feeder_vbuf: dual DEPTHxDW register file, 1 write port and
//    1 async read port, instantiated twice (A, B).
// TESTING
//  1 A=1,2,3,4 B=5,6,7,8 len=4, aff=bff=0 -> pe_start once; 4 consecutive awe/bwe
//    pairs (1,5)..(4,8); PE model fout s_out=70 -> res=70, done pulse, busy=0.
//  2 same job, pe_aff=1 for 3 cycles after the 2nd pair -> no awe/bwe during the
//    stall; pairs 3,4 follow in order; res=70.
//  3 len=0 -> done next cycle, res=0, pe_start never asserted; len=20 -> cfg_err,
//    busy stays 0.
//  4 rst_n low during STREAM after 2 pairs -> all outputs 0 at once; a new go with
//    len=4 restarts from idx 0.
//  5 fout returns before the last pair (early PE model) with s_out=-3, sat=1 ->
//    done only after pair N-1, res=-3, res_sat=1.
//  6 FEEDER_PACE_EN, len=4 -> awe pattern 1,0,1,0,1,0,1 from first issue.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared defaults and FSM state encoding for the PE operand feeder.
package pe_pkg;

  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 16;
  localparam int CW_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_STREAM = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

endpackage

// File: rtl/feeder_vbuf.sv
// Local operand vector buffer: DEPTH x DW register file, one write port, one async read port.
module feeder_vbuf #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pe_operand_feeder.sv
// Drives one systolic PE: start pulse, N operand pairs under full-flag stalls, result capture.
// Optional FEEDER_PACE_EN forces an idle cycle between consecutive pairs.
module pe_operand_feeder
  import pe_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_we,
  input  logic                       ld_sel,
  input  logic [$clog2(DEPTH)-1:0]   ld_addr,
  input  logic [DW-1:0]              ld_data,
  input  logic                       go,
  input  logic [CW-1:0]              len,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic signed [DW-1:0]       res,
  output logic                       res_sat,
  output logic                       pe_start,
  output logic                       pe_awe,
  output logic                       pe_bwe,
  output logic [DW-1:0]              pe_a,
  output logic [DW-1:0]              pe_b,
  output logic                       pe_ais,
  output logic                       pe_bis,
  output logic [CW-1:0]              pe_max_cntr,
  input  logic                       pe_aff,
  input  logic                       pe_bff,
  input  logic                       pe_fout,
  input  logic                       pe_sat,
  input  logic signed [DW-1:0]       pe_s_out
);

  localparam int AW = $clog2(DEPTH);

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_idx, r_n;
  logic                  r_got, r_done, r_cfg_err, r_res_sat;
  logic signed [DW-1:0]  r_res;
  logic                  w_issue, w_last, w_len_zero, w_len_bad, w_have_res, w_pace_ok;
  logic                  w_wr_a, w_wr_b;
  logic [DW-1:0]         w_a_rd, w_b_rd;

  assign w_wr_a = ld_we && (r_state == ST_IDLE) && !ld_sel;
  assign w_wr_b = ld_we && (r_state == ST_IDLE) &&  ld_sel;

  feeder_vbuf #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_vbuf_a (
    .clk(clk), .i_we(w_wr_a), .i_waddr(ld_addr), .i_wdata(ld_data),
    .i_raddr(r_idx[AW-1:0]), .o_rdata(w_a_rd)
  );

  feeder_vbuf #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_vbuf_b (
    .clk(clk), .i_we(w_wr_b), .i_waddr(ld_addr), .i_wdata(ld_data),
    .i_raddr(r_idx[AW-1:0]), .o_rdata(w_b_rd)
  );

`ifdef FEEDER_PACE_EN
  logic r_gap;
  assign w_pace_ok = !r_gap;
`else
  assign w_pace_ok = 1'b1;
`endif

  // Handshake: a pair transfers on any cycle with pe_awe=pe_bwe=1; these are raised
  // only in STREAM when neither pe_aff nor pe_bff is set, so the full flags act as ready.
  assign w_issue    = (r_state == ST_STREAM) && !pe_aff && !pe_bff && w_pace_ok;
  assign w_last     = (r_idx == r_n - CW'(1));
  assign w_len_zero = (len == '0);
  assign w_len_bad  = ({1'b0, len} > (CW+1)'(DEPTH));
  assign w_have_res = r_got || pe_fout;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (go && !w_len_zero && !w_len_bad) w_state_nxt = ST_START;
      ST_START:  w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_issue && w_last) w_state_nxt = ST_WAIT;
      ST_WAIT:   if (w_have_res) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_n       <= '0;
      r_got     <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_res     <= '0;
      r_res_sat <= 1'b0;
`ifdef FEEDER_PACE_EN
      r_gap     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
`ifdef FEEDER_PACE_EN
      r_gap     <= w_issue;
`endif
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            if (w_len_zero) begin
              r_done    <= 1'b1;
              r_res     <= '0;
              r_res_sat <= 1'b0;
            end else if (w_len_bad) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_n <= len;
            end
          end
        end
        ST_START: begin
          r_idx <= '0;
          r_got <= 1'b0;
        end
        ST_STREAM: begin
          if (w_issue) r_idx <= r_idx + CW'(1);
          // An early result is held here until the last pair has gone out.
          if (pe_fout) begin
            r_res     <= pe_s_out;
            r_res_sat <= pe_sat;
            r_got     <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (pe_fout) begin
            r_res     <= pe_s_out;
            r_res_sat <= pe_sat;
          end
          if (w_have_res) begin
            r_done <= 1'b1;
            r_got  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign cfg_err     = r_cfg_err;
  assign res         = r_res;
  assign res_sat     = r_res_sat;
  assign pe_start    = (r_state == ST_START);
  assign pe_awe      = w_issue;
  assign pe_bwe      = w_issue;
  assign pe_a        = w_issue ? w_a_rd : '0;
  assign pe_b        = w_issue ? w_b_rd : '0;
  assign pe_ais      = 1'b0;
  assign pe_bis      = 1'b0;
  assign pe_max_cntr = r_n;

endmodule
